// File: rtl/ariane_axi.sv
// Ariane AXI request/response bundles plus helpers that derive the line
// beat count and the beat size from the line and bus widths.
package ariane_axi;

  localparam int unsigned IdWidth   = 10;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 256;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;

  typedef enum logic { SINGLE_REQ, CACHE_LINE_REQ } ad_req_t;

  typedef struct packed {
    id_t             id;
    addr_t           addr;
    axi_pkg::len_t   len;
    axi_pkg::size_t  size;
    axi_pkg::burst_t burst;
  } ax_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t            id;
    axi_pkg::resp_t resp;
  } b_chan_t;

  typedef struct packed {
    id_t            id;
    data_t          data;
    axi_pkg::resp_t resp;
    logic           last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  // Number of bus beats needed to move one cache line.
  function automatic int unsigned line_beats(input int unsigned line_width,
                                             input int unsigned data_width);
    return line_width / data_width;
  endfunction

  // AXI size code of a full-width beat: log2 of the bus width in bytes.
  function automatic int unsigned beat_size(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_line_adapter_pkg.sv
// Local types for the line adapter: the transaction state machine encoding
// and a line-alignment helper.
package axi_line_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    WAIT_B   = 3'd2,
    READ     = 3'd3,
    COMPLETE = 3'd4
  } state_t;

  // Round a byte address down to a power-of-two boundary.
  function automatic logic [63:0] align_down(input logic [63:0] addr,
                                             input int unsigned bytes);
    return addr & ~(64'(bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/axi_pkg.sv
// AXI encodings shared by AXI masters and slaves: burst types, response codes
// and the width types of the len/size/burst/resp fields.
package axi_pkg;

  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;
  typedef logic [2:0] size_t;
  typedef logic [7:0] len_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_line_adapter.sv
// Adapts single-word and cache-line requests onto one AXI master port.
// One transaction in flight; line reads may be issued critical-word-first.
module axi_line_adapter
  import axi_line_adapter_pkg::*;
#(
  parameter int unsigned LINE_WIDTH          = 256,
  parameter int unsigned AXI_DATA_WIDTH      = 64,
  parameter int unsigned AXI_ID_WIDTH        = 10,
  parameter bit          CRITICAL_WORD_FIRST = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  ariane_axi::ad_req_t       type_i,
  output logic                      gnt_o,
  output logic [AXI_ID_WIDTH-1:0]   gnt_id_o,
  input  logic [63:0]               addr_i,
  input  logic                      we_i,
  input  logic [LINE_WIDTH-1:0]     wdata_i,
  input  logic [LINE_WIDTH/8-1:0]   be_i,
  input  logic [2:0]                size_i,
  input  logic [AXI_ID_WIDTH-1:0]   id_i,
  output logic                      valid_o,
  output logic [LINE_WIDTH-1:0]     rdata_o,
  output logic [AXI_ID_WIDTH-1:0]   id_o,
  output logic                      err_o,
  output logic [AXI_DATA_WIDTH-1:0] critical_word_o,
  output logic                      critical_word_valid_o,
  output ariane_axi::req_t          axi_req_o,
  input  ariane_axi::resp_t         axi_resp_i
);

  localparam int unsigned BEATS      = ariane_axi::line_beats(LINE_WIDTH, AXI_DATA_WIDTH);
  localparam int unsigned SIZE_LOG   = ariane_axi::beat_size(AXI_DATA_WIDTH);
  localparam int unsigned IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(BEATS - 1);

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        cnt_r, offset_r;
  logic                    aw_done_r, w_done_r, single_r, err_r;
  logic [AXI_ID_WIDTH-1:0] id_r;

  logic                    single_s;
  logic [IDX_W-1:0]        last_idx_s, rd_idx_s;
  logic [63:0]             line_addr_s;
  logic                    aw_fire_s, w_fire_s, ar_fire_s, r_fire_s;

  // The request type is live in IDLE and remembered once the FSM leaves it.
  assign single_s    = (state_r == IDLE) ? (type_i == ariane_axi::SINGLE_REQ) : single_r;
  assign last_idx_s  = single_s ? {IDX_W{1'b0}} : IDX_MASK;
  assign line_addr_s = align_down(addr_i, LINE_BYTES);
  // Critical-word-first reads wrap around the line starting at the latched offset.
  assign rd_idx_s    = single_r ? {IDX_W{1'b0}} :
                       (CRITICAL_WORD_FIRST ? ((offset_r + cnt_r) & IDX_MASK) : cnt_r);

  assign aw_fire_s = axi_req_o.aw_valid & axi_resp_i.aw_ready;
  assign w_fire_s  = axi_req_o.w_valid  & axi_resp_i.w_ready;
  assign ar_fire_s = axi_req_o.ar_valid & axi_resp_i.ar_ready;
  assign r_fire_s  = axi_req_o.r_ready  & axi_resp_i.r_valid;

  assign gnt_id_o        = id_i;
  assign critical_word_o = axi_resp_i.r.data[AXI_DATA_WIDTH-1:0];

  // Next state, AXI channel drive and requester strobes; all strobes held low in reset.
  always_comb begin
    state_s               = state_r;
    axi_req_o             = '0;
    gnt_o                 = 1'b0;
    valid_o               = 1'b0;
    id_o                  = id_r;
    err_o                 = 1'b0;
    critical_word_valid_o = 1'b0;

    axi_req_o.aw.id    = ariane_axi::id_t'(id_i);
    axi_req_o.aw.addr  = single_s ? addr_i : line_addr_s;
    axi_req_o.aw.len   = single_s ? 8'd0 : 8'(BEATS - 1);
    axi_req_o.aw.size  = single_s ? size_i : 3'(SIZE_LOG);
    axi_req_o.aw.burst = axi_pkg::BURST_INCR;
    axi_req_o.w.data   = ariane_axi::data_t'(wdata_i[int'(cnt_r)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]);
    axi_req_o.w.strb   = ariane_axi::strb_t'(be_i[int'(cnt_r)*STRB_W +: STRB_W]);
    axi_req_o.w.last   = (cnt_r == last_idx_s);
    axi_req_o.ar.id    = ariane_axi::id_t'(id_i);
    axi_req_o.ar.addr  = (single_s || CRITICAL_WORD_FIRST) ? addr_i : line_addr_s;
    axi_req_o.ar.len   = single_s ? 8'd0 : 8'(BEATS - 1);
    axi_req_o.ar.size  = single_s ? size_i : 3'(SIZE_LOG);
    axi_req_o.ar.burst = (!single_s && CRITICAL_WORD_FIRST) ? axi_pkg::BURST_WRAP : axi_pkg::BURST_INCR;

    if (rst_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_i && we_i) begin
            axi_req_o.aw_valid = 1'b1;
            axi_req_o.w_valid  = 1'b1;
            if (axi_resp_i.aw_ready && axi_resp_i.w_ready && (last_idx_s == {IDX_W{1'b0}})) begin
              gnt_o   = 1'b1;
              state_s = WAIT_B;
            end else begin
              state_s = WRITE;
            end
          end else if (req_i) begin
            axi_req_o.ar_valid = 1'b1;
            if (axi_resp_i.ar_ready) begin
              gnt_o   = 1'b1;
              state_s = READ;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = IDLE;
          end
        end
        WRITE: begin
          axi_req_o.aw_valid = !aw_done_r;
          axi_req_o.w_valid  = !w_done_r;
          if ((aw_done_r || axi_resp_i.aw_ready) &&
              (w_done_r || (axi_resp_i.w_ready && (cnt_r == last_idx_s)))) begin
            gnt_o   = 1'b1;
            state_s = WAIT_B;
          end else begin
            state_s = WRITE;
          end
        end
        WAIT_B: begin
          axi_req_o.b_ready = 1'b1;
          if (axi_resp_i.b_valid) begin
            valid_o = 1'b1;
            id_o    = AXI_ID_WIDTH'(axi_resp_i.b.id);
            err_o   = axi_resp_i.b.resp[1];
            state_s = IDLE;
          end else begin
            state_s = WAIT_B;
          end
        end
        READ: begin
          axi_req_o.r_ready = 1'b1;
          if (axi_resp_i.r_valid) begin
            critical_word_valid_o = !single_r && (rd_idx_s == offset_r);
            state_s = axi_resp_i.r.last ? COMPLETE : READ;
          end else begin
            state_s = READ;
          end
        end
        COMPLETE: begin
          valid_o = 1'b1;
          id_o    = id_r;
          err_o   = err_r;
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, beat counter, handshake flags, read line assembly and latched completion info.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= {IDX_W{1'b0}};
      offset_r  <= {IDX_W{1'b0}};
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      single_r  <= 1'b0;
      err_r     <= 1'b0;
      id_r      <= {AXI_ID_WIDTH{1'b0}};
      rdata_o   <= {LINE_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE, WRITE: begin
          if (state_r == IDLE && req_i) begin
            single_r <= (type_i == ariane_axi::SINGLE_REQ);
          end
          if (ar_fire_s) begin
            offset_r <= IDX_W'(addr_i >> SIZE_LOG) & IDX_MASK;
          end
          if (gnt_o) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            cnt_r     <= {IDX_W{1'b0}};
          end else begin
            if (aw_fire_s) begin
              aw_done_r <= 1'b1;
            end
            if (w_fire_s) begin
              if (cnt_r == last_idx_s) begin
                w_done_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + IDX_W'(1);
              end
            end
          end
        end
        READ: begin
          if (r_fire_s) begin
            rdata_o[int'(rd_idx_s)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <=
              axi_resp_i.r.data[AXI_DATA_WIDTH-1:0];
            err_r <= err_r | axi_resp_i.r.resp[1];
            cnt_r <= cnt_r + IDX_W'(1);
            if (axi_resp_i.r.last) begin
              id_r <= AXI_ID_WIDTH'(axi_resp_i.r.id);
            end
          end
        end
        COMPLETE: begin
          err_r <= 1'b0;
          cnt_r <= {IDX_W{1'b0}};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
